matrix_stream_host: RTL

MATRIX_STREAM_HOST -- requirements
Module: matrix_stream_host

---
 rtl/matrix_stream_host.sv | 106 ++++++++++
 1 files changed

// File: rtl/matrix_stream_host.sv
// Streams two 4x4 byte matrices into a multiplier, waits for its result and
// streams the 16 result elements back out row-major, with a done-timeout guard.
module matrix_stream_host #(
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic [127:0] mm_a,
    output logic [127:0] mm_b,
    output logic         mm_start,
    input  logic         mm_done,
    input  logic [255:0] mm_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  out_data,
    output logic         out_last,
    output logic         timeout_err
);

    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;

    localparam logic [15:0] WLAST = 16'(DONE_TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [15:0][7:0]  a_q, b_q;
    logic [15:0][15:0] res_q;
    logic [4:0]        bidx;
    logic [3:0]        oidx;
    logic [15:0]       wcnt;

    assign mm_a = a_q;
    assign mm_b = b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    if (in_valid && bidx == 5'd31) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (mm_done) state_nxt = UNLOAD;
                     else if (wcnt == WLAST) state_nxt = LOAD;
            UNLOAD:  if (out_ready && oidx == 4'd15) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // out_data is forced to zero outside UNLOAD so idle output stays quiet
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        unique case (state)
            LOAD:   in_ready = 1'b1;
            UNLOAD: begin
                out_valid = 1'b1;
                out_data  = res_q[oidx];
                out_last  = (oidx == 4'd15);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            bidx        <= '0;
            oidx        <= '0;
            wcnt        <= '0;
            mm_start    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mm_start <= (state_nxt == START);
            unique case (state)
                LOAD: if (in_valid) begin
                    if (bidx[4]) b_q[bidx[3:0]] <= in_data;
                    else         a_q[bidx[3:0]] <= in_data;
                    bidx <= bidx + 5'd1;
                end
                START: wcnt <= '0;
                // done wins over the timeout on the final count
                WAIT: if (mm_done) begin
                    res_q <= mm_c;
                    oidx  <= '0;
                end else if (wcnt == WLAST) begin
                    timeout_err <= 1'b1;
                    bidx        <= '0;
                end else begin
                    wcnt <= wcnt + 16'd1;
                end
                UNLOAD: if (out_ready) oidx <= oidx + 4'd1;
                default: ;
            endcase
        end
    end

endmodule
